// File: rtl/sram_mem_ctrl_pkg.sv
// Shared settings for the memory-stage SRAM controller.
//   WORD_WIDTH macro (default 32) sets the pipeline word width; the SRAM is a
//   16-bit device addressed in half-words through an 18-bit address bus.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package sram_mem_ctrl_pkg;

    localparam int unsigned WORD_W                = `WORD_WIDTH;
    localparam int unsigned SRAM_AW               = 18;
    localparam int unsigned SRAM_DW               = 16;
    localparam int unsigned CNT_W                 = 16;
    localparam int unsigned DATA_MEM_BASE_DEFAULT = 1024;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StHigh = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline-side request/response bundle between the EXE/MEM register and the
// SRAM controller.
//   master : pipeline (drives mem_read_in/mem_write_in/address_in/wdata_in)
//   slave  : controller (drives rdata_out/ready/freeze)
interface sram_mem_ctrl_if;
    import sram_mem_ctrl_pkg::*;

    logic              mem_read_in;
    logic              mem_write_in;
    logic [WORD_W-1:0] address_in;
    logic [WORD_W-1:0] wdata_in;
    logic [WORD_W-1:0] rdata_out;
    logic              ready;
    logic              freeze;

    modport master (
        output mem_read_in, mem_write_in, address_in, wdata_in,
        input  rdata_out, ready, freeze
    );

    modport slave (
        input  mem_read_in, mem_write_in, address_in, wdata_in,
        output rdata_out, ready, freeze
    );

endinterface

// File: rtl/sram_wait_timer.sv
// Wait-state timer for one half-word SRAM phase.
//   clk, rst : clock and synchronous active-high reset
//   load     : reload with WAIT_CYCLES-1 (asserted in the cycle before a phase starts)
//   last     : high in the final cycle of the phase (count reached zero)
module sram_wait_timer #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 4'(WAIT_CYCLES - 1);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two half-word
// SRAM accesses (low half first), each WAIT_CYCLES long, and reassembles load
// data. freeze holds the pipeline while a request is outstanding; ready pulses
// for one cycle when the access completes.
//   clk, rst          : clock, synchronous active-high reset
//   pipe (slave)      : mem_read_in/mem_write_in/address_in/wdata_in -> rdata_out/ready/freeze
//   sram_addr         : half-word address {word index, half select}
//   sram_dq_out/_oe   : write data and bus drive enable
//   sram_dq_in        : read data from SRAM
//   sram_we_n         : active-low write enable
//   read_count/write_count : completed-op counters, only when SRAM_MEM_CTRL_STATS_EN is defined
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES   = 2,
    parameter int unsigned DATA_MEM_BASE = DATA_MEM_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    sram_mem_ctrl_if.slave     pipe,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
`ifdef SRAM_MEM_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]   read_count,
    output logic [CNT_W-1:0]   write_count
`endif
);

    state_e               state_q, state_d;
    logic                 write_q;
    logic [SRAM_AW-2:0]   idx_q;
    logic [WORD_W-1:0]    wdata_q;
    logic [WORD_W-1:0]    rdata_q;
    logic                 req;
    logic [SRAM_AW-2:0]   idx_next;
    logic                 tmr_load;
    logic                 tmr_last;
    logic                 in_high;
    logic                 active;

    assign req      = pipe.mem_read_in | pipe.mem_write_in;
    // Byte offset from the data base, dropped to a word index; bits [1:0] ignored.
    assign idx_next = (SRAM_AW - 1)'((pipe.address_in - WORD_W'(DATA_MEM_BASE)) >> 2);

    sram_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .last (tmr_last)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d  = StLow;
                    tmr_load = 1'b1;
                end
            end
            StLow: begin
                if (tmr_last) begin
                    state_d  = StHigh;
                    tmr_load = 1'b1;
                end
            end
            StHigh: begin
                if (tmr_last) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                // Simultaneous read and write resolves to a write.
                write_q <= pipe.mem_write_in;
                idx_q   <= idx_next;
                wdata_q <= pipe.wdata_in;
            end
            if (!write_q && tmr_last) begin
                if (state_q == StLow)  rdata_q[SRAM_DW-1:0]      <= sram_dq_in;
                if (state_q == StHigh) rdata_q[WORD_W-1:SRAM_DW] <= sram_dq_in;
            end
        end
    end

    assign in_high     = (state_q == StHigh);
    assign active      = (state_q == StLow) | in_high;
    assign sram_addr   = {idx_q, in_high};
    assign sram_dq_out = in_high ? wdata_q[WORD_W-1:SRAM_DW] : wdata_q[SRAM_DW-1:0];
    assign sram_dq_oe  = active & write_q;
    assign sram_we_n   = ~(active & write_q);

    assign pipe.rdata_out = rdata_q;
    assign pipe.ready     = (state_q == StDone);
    assign pipe.freeze    = req & ~pipe.ready;

`ifdef SRAM_MEM_CTRL_STATS_EN
    logic [CNT_W-1:0] read_count_q, write_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else if (state_q == StDone) begin
            if (write_q && write_count_q != '1) write_count_q <= write_count_q + 1'b1;
            if (!write_q && read_count_q != '1) read_count_q <= read_count_q + 1'b1;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: a W=2 instance (a) and a W=1 instance (b) share one
// behavioural SRAM; expectations come from a word-level reference memory.
module tb_sram_mem_ctrl;
    import sram_mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        sel = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_init = 1'b1;

    sram_mem_ctrl_if if_a ();
    sram_mem_ctrl_if if_b ();

    assign if_a.mem_read_in  = req_rd & ~sel;
    assign if_a.mem_write_in = req_wr & ~sel;
    assign if_a.address_in   = req_addr;
    assign if_a.wdata_in     = req_wdata;
    assign if_b.mem_read_in  = req_rd & sel;
    assign if_b.mem_write_in = req_wr & sel;
    assign if_b.address_in   = req_addr;
    assign if_b.wdata_in     = req_wdata;

    logic [17:0] addr_a, addr_b;
    logic [15:0] dqo_a, dqo_b, dqi_a, dqi_b;
    logic        oe_a, oe_b, wen_a, wen_b;
`ifdef SRAM_MEM_CTRL_STATS_EN
    logic [15:0] rc_a, wc_a, rc_b, wc_b;
`endif

    sram_mem_ctrl #(.WAIT_CYCLES(2), .DATA_MEM_BASE(1024)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .pipe        (if_a),
        .sram_addr   (addr_a),
        .sram_dq_out (dqo_a),
        .sram_dq_oe  (oe_a),
        .sram_dq_in  (dqi_a),
        .sram_we_n   (wen_a)
`ifdef SRAM_MEM_CTRL_STATS_EN
        ,
        .read_count  (rc_a),
        .write_count (wc_a)
`endif
    );

    sram_mem_ctrl #(.WAIT_CYCLES(1), .DATA_MEM_BASE(1024)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .pipe        (if_b),
        .sram_addr   (addr_b),
        .sram_dq_out (dqo_b),
        .sram_dq_oe  (oe_b),
        .sram_dq_in  (dqi_b),
        .sram_we_n   (wen_b)
`ifdef SRAM_MEM_CTRL_STATS_EN
        ,
        .read_count  (rc_b),
        .write_count (wc_b)
`endif
    );

    // Behavioural half-word SRAM: asynchronous read, write on clock edge.
    function automatic logic [15:0] init_hw(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_hw(i);
        end else begin
            if (!wen_a) mem[addr_a[7:0]] <= dqo_a;
            if (!wen_b) mem[addr_b[7:0]] <= dqo_b;
        end
    end
    assign dqi_a = mem[addr_a[7:0]];
    assign dqi_b = mem[addr_b[7:0]];

    // Observation mux for the instance under test.
    logic        ready_m, freeze_m, oe_m, wen_m;
    logic [17:0] addr_m;
    logic [15:0] dqo_m;
    logic [31:0] rdata_m;
    assign ready_m  = sel ? if_b.ready     : if_a.ready;
    assign freeze_m = sel ? if_b.freeze    : if_a.freeze;
    assign rdata_m  = sel ? if_b.rdata_out : if_a.rdata_out;
    assign oe_m     = sel ? oe_b   : oe_a;
    assign wen_m    = sel ? wen_b  : wen_a;
    assign addr_m   = sel ? addr_b : addr_a;
    assign dqo_m    = sel ? dqo_b  : dqo_a;

    // Reference model: word memory, last load result and op counts per instance.
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_rd [2];
    int          exp_rc [2];
    int          exp_wc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req_rd = 1'b0;
        req_wr = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(ready_m), 32'd0);
        chk("idle_freeze", 32'(freeze_m), 32'd0);
        chk("idle_we_n", 32'({wen_a, wen_b}), 32'd3);
    endtask

    // One full request, checked cycle by cycle from the timing rules.
    task automatic access(input logic s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        int          w;
        logic        isw;
        logic        hi;
        logic [16:0] idx;
        w   = s ? 1 : 2;
        isw = wr;
        idx = 17'((a - 32'd1024) >> 2);
        @(posedge clk);
        #1;
        sel = s; req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        chk("c0_freeze", 32'(freeze_m), 32'd1);
        chk("c0_ready", 32'(ready_m), 32'd0);
        for (int c = 1; c <= 2 * w + 1; c++) begin
            @(negedge clk);
            if (c <= 2 * w) begin
                hi = (c > w);
                chk("sram_addr", 32'(addr_m), 32'({idx, hi}));
                chk("we_n", 32'(wen_m), 32'(!isw));
                chk("oe", 32'(oe_m), 32'(isw));
                if (isw) chk("dq_out", 32'(dqo_m), 32'(hi ? d[31:16] : d[15:0]));
                chk("freeze", 32'(freeze_m), 32'd1);
                chk("ready_early", 32'(ready_m), 32'd0);
            end else begin
                chk("ready", 32'(ready_m), 32'd1);
                chk("done_freeze", 32'(freeze_m), 32'd0);
                chk("done_we_n", 32'(wen_m), 32'd1);
            end
        end
        if (isw) begin
            ref_mem[idx[5:0]] = d;
            if (exp_wc[s] < 65535) exp_wc[s]++;
        end else begin
            exp_rd[s] = ref_mem[idx[5:0]];
            if (exp_rc[s] < 65535) exp_rc[s]++;
        end
        chk("rdata", rdata_m, exp_rd[s]);
`ifdef SRAM_MEM_CTRL_STATS_EN
        chk("read_count", 32'(s ? rc_b : rc_a), 32'(exp_rc[s]));
        chk("write_count", 32'(s ? wc_b : wc_a), 32'(exp_wc[s]));
`endif
    endtask

    initial begin
        logic        rs, rr, rw;
        int          op;
        logic [31:0] ra;
        for (int i = 0; i < 64; i++) ref_mem[i] = {init_hw(2 * i + 1), init_hw(2 * i)};
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = '0;
            exp_rc[i] = 0;
            exp_wc[i] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_rdata", if_a.rdata_out, 32'd0);
        chk("rst_ready", 32'(if_a.ready), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_dq", 32'(dqo_a), 32'd0);
        chk("rst_oe", 32'(oe_a), 32'd0);
        chk("rst_we_n", 32'(wen_a), 32'd1);
        chk("rst_freeze", 32'(if_a.freeze), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset during the low phase of a store abandons it.
        @(posedge clk);
        #1;
        sel = 1'b0; req_wr = 1'b1; req_addr = 32'd1032; req_wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_state", 32'(dut_a.state_q), 32'(StIdle));
        chk("midrst_we_n", 32'(wen_a), 32'd1);
        chk("midrst_ready", 32'(if_a.ready), 32'd0);
        chk("midrst_freeze", 32'(if_a.freeze), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_wr = 1'b0;
        ref_mem[2][15:0] = 16'h5678;
        @(negedge clk);
        chk("postrst_ready", 32'(if_a.ready), 32'd0);

        // Directed store/load of 0xDEADBEEF at byte address 1028.
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0);
        chk("load_deadbeef", if_a.rdata_out, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 1'b0, 32'd1034, 32'd0);
        // Back-to-back load then store; no idle gap in between.
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0);
        access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0BAD_F00D);
`ifdef SRAM_MEM_CTRL_STATS_EN
        chk("stats_reads3", 32'(rc_a), 32'd3);
        chk("stats_writes2", 32'(wc_a), 32'd2);
`endif
        idle();

        // Single-cycle wait states, including read+write resolving to a write.
        access(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0);
        access(1'b1, 1'b1, 1'b1, 32'd1044, 32'hCAFE_F00D);
        access(1'b1, 1'b1, 1'b0, 32'd1044, 32'd0);
        chk("w1_both_is_write", if_b.rdata_out, 32'hCAFE_F00D);
        idle();

`ifdef SRAM_MEM_CTRL_STATS_EN
        force dut_a.read_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_a.read_count_q;
        exp_rc[0] = 65535;
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0);
        chk("stats_saturate", 32'(rc_a), 32'h0000_FFFF);
        idle();
`endif

        for (int k = 0; k < 40; k++) begin
            rs = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            rr = (op != 1);
            rw = (op != 0);
            ra = 32'd1024 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            access(rs, rr, rw, ra, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
